// File: rtl/sam_memory_ctrl.sv
// rtl/sam_memory_ctrl.sv - multi-cycle word memory with REQUEST/RW/WAIT handshake
//
// Purpose:
//   Slow word memory serving the SAM datapath. A request is accepted in IDLE,
//   held in BUSY for a fixed LATENCY, performed on the access edge, and the
//   result is presented in DONE until the requester drops REQUEST.
//
// Parameters:
//   ADDR_BITS   implemented address bits (depth = 2**ADDR_BITS 16-bit words)
//   LATENCY     edges from the accept edge to the access edge (1..15)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ADDRESS_BUS  in   word address, sampled on the accept edge
//   REQUEST      in   level-held access request
//   RW           in   1 = read, 0 = write, sampled on the accept edge
//   data_in      in   write data, sampled on the accept edge
//   WAIT         out  high while a request is presented or in progress
//   data_out     out  read data or echo of the written word
//   addr_err     out  last completed access addressed beyond the array

module sam_memory_ctrl #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ADDRESS_BUS,
   input  logic        REQUEST,
   input  logic        RW,
   input  logic [15:0] data_in,
   output logic        WAIT,
   output logic [15:0] data_out,
   output logic        addr_err
);

   localparam int         DEPTH    = 1 << ADDR_BITS;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q;
   logic [3:0]             cnt_q;
   logic [15:0]            addr_q;
   logic [15:0]            wdata_q;
   logic                   rw_q;
   logic [15:0]            data_out_q;
   logic                   addr_err_q;

   // Storage is deliberately not reset; contents survive rst_n.
   logic [15:0]            mem [DEPTH];

   logic                   access_now;
   logic                   in_range;
   logic                   mem_we;
   logic [ADDR_BITS-1:0]   word_idx;

   assign access_now = (state_q == S_BUSY) && (cnt_q == 4'd0);
   // Upper address bits are checked rather than dropped, so no aliasing.
   assign in_range   = ((addr_q >> ADDR_BITS) == 16'd0);
   assign word_idx   = addr_q[ADDR_BITS-1:0];
   // state_q is forced to IDLE asynchronously, so no write can happen in reset.
   assign mem_we     = access_now && !rw_q && in_range;

   // In IDLE the requester sees WAIT follow REQUEST in the same cycle.
   assign WAIT     = rst_n && ((state_q == S_IDLE) ? REQUEST : (state_q == S_BUSY));
   assign data_out = data_out_q;
   assign addr_err = addr_err_q;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[word_idx] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= 16'd0;
         wdata_q    <= 16'd0;
         rw_q       <= 1'b0;
         data_out_q <= 16'd0;
         addr_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (REQUEST) begin
                  addr_q  <= ADDRESS_BUS;
                  wdata_q <= data_in;
                  rw_q    <= RW;
                  cnt_q   <= CNT_LOAD;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cnt_q == 4'd0) begin
                  if (!in_range) begin
                     data_out_q <= 16'd0;
                     addr_err_q <= 1'b1;
                  end else if (rw_q) begin
                     data_out_q <= mem[word_idx];
                     addr_err_q <= 1'b0;
                  end else begin
                     data_out_q <= wdata_q;
                     addr_err_q <= 1'b0;
                  end
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_DONE: begin
               // REQUEST must be seen low for an edge before a new access.
               if (!REQUEST) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sam_memory_ctrl.sv
// tb/tb_sam_memory_ctrl.sv - scoreboard bench for sam_memory_ctrl at LATENCY 3, 1 and 7

module tb_sam_memory_ctrl;

   localparam int AB   = 8;
   localparam int NINST = 3;

   typedef struct {
      logic [15:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] ADDRESS_BUS;
   logic        REQUEST;
   logic        RW;
   logic [15:0] data_in;
   logic        wait_s  [NINST];
   logic [15:0] dout_s  [NINST];
   logic        aerr_s  [NINST];

   int          checks;
   int          errors;

   exp_t        sb_q    [NINST][$];
   int          wcnt    [NINST];
   logic [15:0] ref_mem [int];
   logic [15:0] written [$];
   logic [15:0] last_data;
   logic        last_err;

   function automatic int lat_of(input int i);
      return (i == 0) ? 3 : (i == 1) ? 1 : 7;
   endfunction

   for (genvar g = 0; g < NINST; g++) begin : g_dut
      sam_memory_ctrl #(
         .ADDR_BITS (AB),
         .LATENCY   ((g == 0) ? 3 : (g == 1) ? 1 : 7)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .ADDRESS_BUS (ADDRESS_BUS),
         .REQUEST     (REQUEST),
         .RW          (RW),
         .data_in     (data_in),
         .WAIT        (wait_s[g]),
         .data_out    (dout_s[g]),
         .addr_err    (aerr_s[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d: got %h expected %h", name, inst, act, exp);
      end
   endtask

   // Monitor: a completed access shows up as WAIT falling while out of reset.
   // WAIT is high on the negedge before the accept edge plus LATENCY more.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < NINST; i++) begin
         if (!rst_n) begin
            wcnt[i] = 0;
         end else if (wait_s[i]) begin
            wcnt[i]++;
         end else if (wcnt[i] != 0) begin
            if (sb_q[i].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_access inst=%0d: got data_out %h expected no access", i, dout_s[i]);
            end else begin
               e = sb_q[i].pop_front();
               check("data_out", i, 32'(dout_s[i]), 32'(e.data));
               check("addr_err", i, 32'(aerr_s[i]), 32'(e.err));
               check("wait_cycles", i, 32'(wcnt[i]), 32'(lat_of(i) + 1));
            end
            wcnt[i] = 0;
         end
      end
   end

   // Reference model: plain memory semantics, upper bits must be zero.
   task automatic push_exp(input logic [15:0] a, input logic rw, input logic [15:0] d);
      exp_t e;
      if ((a >> AB) != 16'd0) begin
         e.data = 16'd0;
         e.err  = 1'b1;
      end else if (rw) begin
         e.data = ref_mem[int'(a)];
         e.err  = 1'b0;
      end else begin
         ref_mem[int'(a)] = d;
         written.push_back(a);
         e.data = d;
         e.err  = 1'b0;
      end
      for (int i = 0; i < NINST; i++) sb_q[i].push_back(e);
      last_data = e.data;
      last_err  = e.err;
   endtask

   task automatic do_txn(input logic [15:0] a, input logic rw, input logic [15:0] d,
                         input int hold, input bit scramble, input bit drop_early);
      bit done;
      @(posedge clk); #1;
      rst_n       = 1'b1;
      ADDRESS_BUS = a;
      RW          = rw;
      data_in     = d;
      REQUEST     = 1'b1;
      #1;
      for (int i = 0; i < NINST; i++) begin
         check("wait_on_request", i, 32'(wait_s[i]), 32'd1);
         check("data_hold", i, 32'(dout_s[i]), 32'(last_data));
         check("err_hold", i, 32'(aerr_s[i]), 32'(last_err));
      end
      push_exp(a, rw, d);
      @(posedge clk); #1;
      if (scramble) begin
         ADDRESS_BUS = 16'($urandom);
         RW          = 1'($urandom);
         data_in     = 16'($urandom);
      end
      if (drop_early) REQUEST = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         done = 1'b1;
         for (int i = 0; i < NINST; i++) if (wait_s[i] !== 1'b0) done = 1'b0;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL completion_timeout inst=all: got WAIT still high expected low within 20 cycles");
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         for (int i = 0; i < NINST; i++) check("wait_in_done", i, 32'(wait_s[i]), 32'd0);
      end
      @(posedge clk); #1;
      REQUEST = 1'b0;
   endtask

   task automatic abort_write(input logic [15:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      ADDRESS_BUS = a;
      RW          = 1'b0;
      data_in     = d;
      REQUEST     = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NINST; i++) begin
         check("abort_wait", i, 32'(wait_s[i]), 32'd0);
         check("abort_data", i, 32'(dout_s[i]), 32'd0);
      end
      @(posedge clk); #1;
      rst_n   = 1'b1;
      REQUEST = 1'b0;
      last_data = 16'd0;
      last_err  = 1'b0;
      #1;
      for (int i = 0; i < NINST; i++) check("idle_after_abort", i, 32'(wait_s[i]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000ns");
      $fatal(1);
   end

   initial begin
      logic [15:0] a;
      logic [15:0] d;
      logic        rw;
      int          r;

      checks      = 0;
      errors      = 0;
      last_data   = 16'd0;
      last_err    = 1'b0;
      rst_n       = 1'b0;
      ADDRESS_BUS = 16'h0012;
      RW          = 1'b0;
      data_in     = 16'hBEEF;
      REQUEST     = 1'b1;
      for (int i = 0; i < NINST; i++) wcnt[i] = 0;

      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < NINST; i++) begin
            check("reset_wait", i, 32'(wait_s[i]), 32'd0);
            check("reset_data", i, 32'(dout_s[i]), 32'd0);
            check("reset_err", i, 32'(aerr_s[i]), 32'd0);
         end
      end

      // Reset released with REQUEST already high.
      do_txn(16'h0012, 1'b0, 16'hBEEF, 0, 1'b0, 1'b0);
      do_txn(16'h0012, 1'b1, 16'h0000, 0, 1'b0, 1'b0);
      do_txn(16'h0000, 1'b0, 16'hCAFE, 1, 1'b0, 1'b0);
      do_txn(16'h0100, 1'b0, 16'h1234, 0, 1'b0, 1'b0);
      do_txn(16'h0000, 1'b1, 16'h0000, 0, 1'b0, 1'b0);
      do_txn(16'hFF12, 1'b1, 16'h0000, 0, 1'b0, 1'b0);
      do_txn(16'h0012, 1'b1, 16'h0000, 10, 1'b0, 1'b0);
      do_txn(16'h0012, 1'b0, 16'h7001, 0, 1'b1, 1'b0);
      do_txn(16'h0012, 1'b1, 16'h0000, 0, 1'b1, 1'b0);
      do_txn(16'h00FF, 1'b0, 16'h0F0F, 0, 1'b0, 1'b1);
      do_txn(16'h00FF, 1'b1, 16'h0000, 2, 1'b0, 1'b1);

      do_txn(16'h0005, 1'b0, 16'h5555, 0, 1'b0, 1'b0);
      abort_write(16'h0005, 16'hAAAA);
      do_txn(16'h0005, 1'b1, 16'h0000, 0, 1'b0, 1'b0);

      for (int t = 0; t < 40; t++) begin
         r  = int'($urandom_range(0, 9));
         rw = 1'($urandom);
         d  = 16'($urandom);
         if (r < 2) begin
            a = {8'($urandom_range(1, 255)), 8'($urandom)};
         end else if (rw && written.size() > 0) begin
            a = written[$urandom_range(0, written.size() - 1)];
         end else begin
            rw = 1'b0;
            a  = {8'h00, 8'($urandom)};
         end
         do_txn(a, rw, d, int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 4) == 0));
      end

      repeat (12) @(posedge clk);
      #1;
      for (int i = 0; i < NINST; i++) check("scoreboard_empty", i, 32'(sb_q[i].size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
